// File: rtl/log_ctrl_pkg.sv
// Shared types and constants for the log capture/dump controller.
package log_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLog,
        StFull,
        StFetch,
        StSend
    } log_state_e;

    // o_enable bit positions
    localparam int unsigned EN_CLR  = 0;
    localparam int unsigned EN_RUN  = 1;
    localparam int unsigned EN_STEP = 2;

endpackage

// File: rtl/log_ctrl_cnt.sv
// Dump word counter: synchronous clear/increment with a terminal-count flag on the last word.
module log_ctrl_cnt #(
    parameter int unsigned NB_ADDR = 10
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_tc
);

    localparam logic [NB_ADDR:0] LAST = (NB_ADDR + 1)'((1 << NB_ADDR) - 1);

    logic [NB_ADDR:0] count_q;
    logic [NB_ADDR:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_incr) begin
            count_d = count_q + (NB_ADDR + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tc = (count_q == LAST);

endmodule

// File: rtl/log_ctrl_fsm.sv
// Log capture/dump controller; define LOG_CTRL_TIMEOUT_EN to bound the LOG state by TIMEOUT_CYC.
module log_ctrl_fsm
    import log_ctrl_pkg::*;
#(
    parameter int unsigned NB_ADDR     = 10,
    parameter int unsigned NB_DATA     = 16,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_cmd_start,
    input  logic               i_cmd_read,
    input  logic               i_abort,
    input  logic               i_ram_full,
    input  logic [NB_DATA-1:0] i_ram_data,
    output logic [2:0]         o_enable,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

    log_state_e         state_q, state_d;
    logic [2:0]         enable_q, enable_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [2:0]         lat_q, lat_d;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               cnt_tc;
    logic               tmo_hit;

    log_ctrl_cnt #(
        .NB_ADDR (NB_ADDR)
    ) u_cnt (
        .clock   (clock),
        .i_reset (i_reset),
        .i_clear (cnt_clr),
        .i_incr  (cnt_inc),
        .o_tc    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        enable_d = '0;
        data_d   = data_q;
        valid_d  = valid_q;
        lat_d    = '0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_cmd_start) begin
                    state_d          = StLog;
                    enable_d[EN_CLR] = 1'b1;
                end
            end
            StLog: begin
                if (i_ram_full || tmo_hit) begin
                    state_d = StFull;
                end else begin
                    enable_d[EN_RUN] = 1'b1;
                end
            end
            StFull: begin
                // start takes precedence over read
                if (i_cmd_start) begin
                    state_d          = StLog;
                    enable_d[EN_CLR] = 1'b1;
                end else if (i_cmd_read) begin
                    state_d = StFetch;
                    cnt_clr = 1'b1;
                end
            end
            StFetch: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = i_ram_data;
                    valid_d = 1'b1;
                    state_d = StSend;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            StSend: begin
                if (i_ready) begin
                    valid_d           = 1'b0;
                    enable_d[EN_STEP] = 1'b1;
                    cnt_inc           = 1'b1;
                    state_d           = cnt_tc ? StIdle : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        if (i_abort) begin
            state_d  = StIdle;
            enable_d = '0;
            valid_d  = 1'b0;
            lat_d    = '0;
            cnt_inc  = 1'b0;
        end

        busy_d = !(state_d == StIdle || state_d == StFull);
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q  <= StIdle;
            enable_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            lat_q    <= lat_d;
        end
    end

`ifdef LOG_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_q;
    logic             start_go;

    assign tmo_hit  = (state_q == StLog) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign start_go = (state_q == StIdle || state_q == StFull) && i_cmd_start && !i_abort;

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == StLog) ? tmo_q + TMO_W'(1) : '0;
            if (start_go) begin
                timeout_q <= 1'b0;
            end else if (tmo_hit && !i_ram_full && !i_abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_enable = enable_q;
    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_log_ctrl_fsm.sv
// Directed bench for log_ctrl_fsm with a small RAM-stage model (NB_ADDR=3, RD_LAT=2).
module tb_log_ctrl_fsm;

    localparam int unsigned NB_ADDR     = 3;
    localparam int unsigned NB_DATA     = 16;
    localparam int unsigned RD_LAT      = 2;
    localparam int unsigned TIMEOUT_CYC = 100;

    logic               clock = 1'b0;
    logic               i_reset;
    logic               i_cmd_start;
    logic               i_cmd_read;
    logic               i_abort;
    logic               i_ram_full;
    logic [NB_DATA-1:0] i_ram_data;
    logic [2:0]         o_enable;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               i_ready;
    logic               o_busy;
    logic               o_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int n_clr = 0;
    int n_run = 0;
    int n_step = 0;
    int n_multi = 0;
    int s0;
    int s1;
    int c0;
    int r0;
    logic [NB_DATA-1:0] held;

    logic [NB_ADDR-1:0] ram_addr;
    logic [NB_DATA-1:0] ram_pipe;

    log_ctrl_fsm #(
        .NB_ADDR     (NB_ADDR),
        .NB_DATA     (NB_DATA),
        .RD_LAT      (RD_LAT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_cmd_start (i_cmd_start),
        .i_cmd_read  (i_cmd_read),
        .i_abort     (i_abort),
        .i_ram_full  (i_ram_full),
        .i_ram_data  (i_ram_data),
        .o_enable    (o_enable),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] ram_word(input logic [2:0] a);
        return 16'h5A00 + 16'h0111 * {13'd0, a};
    endfunction

    // Address steps on the pulse; one read register gives data two cycles after the step.
    always @(posedge clock) begin
        if (!i_reset) begin
            ram_addr <= '0;
        end else if (o_enable[2]) begin
            ram_addr <= ram_addr + 3'd1;
        end
        ram_pipe <= ram_word(ram_addr);
    end
    assign i_ram_data = ram_pipe;

    always @(negedge clock) begin
        if (o_enable[0]) n_clr++;
        if (o_enable[1]) n_run++;
        if (o_enable[2]) n_step++;
        if ($countones(o_enable) > 1) n_multi++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid();
        int cnt;
        cnt = 0;
        while (!o_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check_val("valid_seen", {31'd0, o_valid}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_cmd_start = 1'b0; i_cmd_read = 1'b0; i_abort = 1'b0;
        i_ram_full = 1'b0; i_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_enable", {29'd0, o_enable}, 32'd0);
        check_val("rst_data", {16'd0, o_data}, 32'd0);
        check_val("rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("rst_busy", {31'd0, o_busy}, 32'd0);
        check_val("rst_timeout", {31'd0, o_timeout}, 32'd0);
        i_reset = 1'b1;
        tick();

        // read is ignored in IDLE
        i_cmd_read = 1'b1;
        repeat (3) tick();
        i_cmd_read = 1'b0;
        check_val("idle_read_busy", {31'd0, o_busy}, 32'd0);
        check_val("idle_read_en", {29'd0, o_enable}, 32'd0);

        // start, then full 50 run cycles later
        c0 = n_clr; r0 = n_run;
        i_cmd_start = 1'b1;
        tick();
        i_cmd_start = 1'b0;
        check_val("start_clr", {29'd0, o_enable}, 32'd1);
        check_val("start_busy", {31'd0, o_busy}, 32'd1);
        i_cmd_read = 1'b1;
        repeat (50) tick();
        check_val("log_run", {29'd0, o_enable}, 32'd2);
        i_cmd_read = 1'b0;
        i_ram_full = 1'b1;
        tick();
        check_val("full_en", {29'd0, o_enable}, 32'd0);
        check_val("full_busy", {31'd0, o_busy}, 32'd0);
        check_val("clr_pulses", n_clr - c0, 32'd1);
        check_val("run_cycles", n_run - r0, 32'd50);

        // start and read together in FULL; full already set leaves LOG after one cycle
        s0 = n_step;
        i_cmd_start = 1'b1; i_cmd_read = 1'b1;
        tick();
        i_cmd_start = 1'b0; i_cmd_read = 1'b0;
        check_val("both_clr", {29'd0, o_enable}, 32'd1);
        check_val("both_busy", {31'd0, o_busy}, 32'd1);
        tick();
        check_val("log_one_cycle", {31'd0, o_busy}, 32'd0);
        check_val("both_no_valid", {31'd0, o_valid}, 32'd0);
        check_val("both_no_step", n_step - s0, 32'd0);

        // full dump with backpressure on word 2
        i_cmd_read = 1'b1;
        tick();
        i_cmd_read = 1'b0;
        check_val("fetch_busy", {31'd0, o_busy}, 32'd1);
        s0 = n_step;
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) i_ready = 1'b0;
            wait_valid();
            check_val("dump_data", {16'd0, o_data}, {16'd0, ram_word(3'(k))});
            if (k == 2) begin
                held = o_data;
                s1 = n_step;
                repeat (10) begin
                    tick();
                    check_val("bp_valid", {31'd0, o_valid}, 32'd1);
                    check_val("bp_data", {16'd0, o_data}, {16'd0, held});
                end
                check_val("bp_no_step", n_step - s1, 32'd0);
                i_ready = 1'b1;
            end
            tick();
            check_val("accept_step", {29'd0, o_enable}, 32'd4);
            check_val("accept_valid", {31'd0, o_valid}, 32'd0);
        end
        check_val("dump_idle", {31'd0, o_busy}, 32'd0);
        tick();
        check_val("dump_steps", n_step - s0, 32'd8);
        check_val("addr_wrap", {29'd0, ram_addr}, 32'd0);

        // abort on word 3
        i_cmd_start = 1'b1;
        tick();
        i_cmd_start = 1'b0;
        tick();
        i_cmd_read = 1'b1;
        tick();
        i_cmd_read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            tick();
        end
        wait_valid();
        check_val("abort_word3", {16'd0, o_data}, {16'd0, ram_word(3'd3)});
        i_ready = 1'b0; i_abort = 1'b1;
        s0 = n_step;
        tick();
        i_abort = 1'b0;
        check_val("abort_busy", {31'd0, o_busy}, 32'd0);
        check_val("abort_valid", {31'd0, o_valid}, 32'd0);
        check_val("abort_en", {29'd0, o_enable}, 32'd0);
        repeat (10) tick();
        check_val("abort_no_step", n_step - s0, 32'd0);
        i_cmd_read = 1'b1;
        repeat (2) tick();
        i_cmd_read = 1'b0;
        check_val("abort_is_idle", {31'd0, o_busy}, 32'd0);

        // reset while a word is being offered
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        i_cmd_start = 1'b1;
        tick();
        i_cmd_start = 1'b0;
        tick();
        i_cmd_read = 1'b1;
        tick();
        i_cmd_read = 1'b0;
        i_ready = 1'b0;
        wait_valid();
        check_val("rd_word0", {16'd0, o_data}, {16'd0, ram_word(3'd0)});
        s0 = n_step;
        i_ready = 1'b1; i_reset = 1'b0;
        tick();
        check_val("mid_rst_en", {29'd0, o_enable}, 32'd0);
        check_val("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check_val("mid_rst_data", {16'd0, o_data}, 32'd0);
        i_reset = 1'b1;
        repeat (2) tick();
        check_val("mid_rst_no_step", n_step - s0, 32'd0);

        // LOG with full never asserted
        i_ram_full = 1'b0;
        i_cmd_start = 1'b1;
        tick();
        i_cmd_start = 1'b0;
`ifdef LOG_CTRL_TIMEOUT_EN
        repeat (99) tick();
        check_val("tmo_pre_busy", {31'd0, o_busy}, 32'd1);
        check_val("tmo_pre_flag", {31'd0, o_timeout}, 32'd0);
        tick();
        check_val("tmo_full_busy", {31'd0, o_busy}, 32'd0);
        check_val("tmo_flag", {31'd0, o_timeout}, 32'd1);
        check_val("tmo_en", {29'd0, o_enable}, 32'd0);
        i_cmd_start = 1'b1;
        tick();
        i_cmd_start = 1'b0;
        check_val("tmo_cleared", {31'd0, o_timeout}, 32'd0);
        check_val("tmo_restart", {29'd0, o_enable}, 32'd1);
`else
        repeat (150) tick();
        check_val("hold_busy", {31'd0, o_busy}, 32'd1);
        check_val("hold_flag", {31'd0, o_timeout}, 32'd0);
        check_val("hold_run", {29'd0, o_enable}, 32'd2);
`endif
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_val("final_abort", {31'd0, o_busy}, 32'd0);
        check_val("enable_onehot0", n_multi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/log_ctrl_fsm.md
LOG_CTRL_FSM -- requirements
Module: log_ctrl_fsm

Interface
REQ-001 Parameter NB_ADDR, default 10: log RAM address width; dump length is 2**NB_ADDR words.
REQ-002 Parameter NB_DATA, default 16: RAM word width.
REQ-003 Parameter RD_LAT, default 2: cycles from read-address step to valid RAM data, range 1..7.
REQ-004 Parameter TIMEOUT_CYC, default 4096: LOG-state timeout in cycles; used only when LOG_CTRL_TIMEOUT_EN is defined.
REQ-005 clock  in  1  system clock; all logic on rising edge.
REQ-006 i_reset  in  1  synchronous, active-low reset.
REQ-007 i_cmd_start  in  1  level; request to start a log capture.
REQ-008 i_cmd_read  in  1  level; request to dump the captured log.
REQ-009 i_abort  in  1  level; return to IDLE from any state.
REQ-010 i_ram_full  in  1  log RAM full flag from the RAM stage.
REQ-011 i_ram_data  in  NB_DATA  RAM read data from the RAM stage.
REQ-012 o_enable  out  3  bit0 log-clear pulse, bit1 log run, bit2 read-address step pulse.
REQ-013 o_data  out  NB_DATA  registered dump word.
REQ-014 o_valid  out  1  o_data is valid; held until accepted.
REQ-015 i_ready  in  1  downstream accepts o_data when o_valid && i_ready.
REQ-016 o_busy  out  1  high in any state except IDLE and FULL.
REQ-017 o_timeout  out  1  sticky flag: capture ended by timeout.

Function
REQ-018 States SHALL be IDLE, LOG, FULL, FETCH and SEND; all outputs SHALL be registered.
REQ-019 IDLE: i_cmd_start SHALL pulse o_enable[0] for one cycle, clear o_timeout, and enter LOG; i_cmd_read SHALL be ignored.
REQ-020 LOG: o_enable[1] SHALL be 1; i_ram_full=1 SHALL enter FULL with o_enable[1]=0 on the next cycle; i_cmd_start and i_cmd_read SHALL be ignored.
REQ-021 If i_ram_full is already 1 on entry to LOG, the block SHALL leave LOG after exactly one cycle.
REQ-022 FULL: i_cmd_read SHALL clear the word counter and the latency counter and enter FETCH; i_cmd_start SHALL behave as in IDLE.
REQ-023 If i_cmd_start and i_cmd_read are both high in FULL, start SHALL win.
REQ-024 FETCH: the block SHALL wait RD_LAT cycles, then latch i_ram_data into o_data, set o_valid=1, and enter SEND.
REQ-025 SEND: o_valid SHALL stay 1 and o_data SHALL stay stable until i_ready=1.
REQ-026 On acceptance in SEND, the block SHALL drop o_valid and pulse o_enable[2] for exactly one cycle on the next cycle.
REQ-027 After acceptance, the NB_ADDR+1-bit word counter SHALL increment; if this was word 2**NB_ADDR-1, the block SHALL enter IDLE, otherwise FETCH.
REQ-028 Exactly 2**NB_ADDR step pulses SHALL occur per complete dump, so the external read address wraps back to 0.
REQ-029 i_abort SHALL enter IDLE on the next cycle from any state, with o_valid=0 and o_enable=0; it SHALL have priority over all commands.
REQ-030 At most one o_enable bit SHALL be high in any cycle.

Reset
REQ-031 While i_reset=0, the block SHALL be in state IDLE with o_enable=0, o_data=0, o_valid=0, o_busy=0, o_timeout=0, and all counters at 0.
REQ-032 Reset mid-dump SHALL abandon the dump without issuing a further o_enable[2] pulse.

Configuration
REQ-033 With LOG_CTRL_TIMEOUT_EN defined, a counter SHALL run in LOG; reaching TIMEOUT_CYC cycles without i_ram_full SHALL enter FULL with o_timeout=1.
REQ-034 Without LOG_CTRL_TIMEOUT_EN, there SHALL be no timeout counter, o_timeout SHALL be tied to 0, and LOG SHALL wait indefinitely.

Structure
REQ-035 Package log_ctrl_pkg SHALL hold the state enumeration typedef and the o_enable bit-index constants (EN_CLR=0, EN_RUN=1, EN_STEP=2).
REQ-036 Sub-module log_ctrl_cnt SHALL implement the parameterised word counter with clear, increment and terminal-count outputs; no other sub-modules.

Verification
REQ-037 Start/full: start pulse, i_ram_full asserted 50 cycles later -> one o_enable[0] pulse; o_enable[1] high for 50 cycles; FULL entered next cycle; o_busy=0.
REQ-038 Dump with NB_ADDR=3, RD_LAT=2, i_ready=1 -> 8 words equal to i_ram_data sampled after each latency; 8 o_enable[2] pulses; then IDLE.
REQ-039 Backpressure: i_ready=0 for 10 cycles in SEND -> o_valid and o_data stable; no step pulse until acceptance.
REQ-040 i_abort on word 3 of 8 -> IDLE next cycle; o_valid=0; no further o_enable[2] pulses.
REQ-041 Timeout, macro defined, TIMEOUT_CYC=100, i_ram_full never set -> FULL at cycle 100 with o_timeout=1; without the macro -> LOG held and o_timeout=0.
REQ-042 Start and read together in FULL -> new capture starts (o_enable[0] pulse); no dump occurs.
